// File: rtl/id_ctrl_seq_if.sv
// Handshake and control-bundle signals between the IF/ID register, the ID decoder and EX.
// master drives instructions and consumes bundles; slave is the decoder.
interface id_ctrl_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_pc_sel;
  logic [2:0]  out_alu_src1;
  logic [3:0]  out_alu_src2;
  logic [19:0] out_alu_op;
  logic        out_mem_en;
  logic        out_mem_wen;
  logic        out_rf_wen;
  logic [2:0]  out_rf_wdata_sel;
  logic [2:0]  out_rf_waddr_sel;
  logic        out_hi_wen;
  logic        out_lo_wen;
  logic        out_temp_wen;
  logic        out_illegal;

  modport master (
    output in_valid, inst, flush, out_ready,
    input  in_ready, out_valid, out_pc_sel, out_alu_src1, out_alu_src2, out_alu_op,
           out_mem_en, out_mem_wen, out_rf_wen, out_rf_wdata_sel, out_rf_waddr_sel,
           out_hi_wen, out_lo_wen, out_temp_wen, out_illegal
  );

  modport slave (
    input  in_valid, inst, flush, out_ready,
    output in_ready, out_valid, out_pc_sel, out_alu_src1, out_alu_src2, out_alu_op,
           out_mem_en, out_mem_wen, out_rf_wen, out_rf_wdata_sel, out_rf_waddr_sel,
           out_hi_wen, out_lo_wen, out_temp_wen, out_illegal
  );
endinterface

// File: rtl/id_ctrl_seq.sv
// Registered MIPS-I ID-stage control decoder with a single-entry output register
// and a HI/LO interlock FSM tracking the multi-cycle multiply/divide unit.
module id_ctrl_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_ctrl_seq_if.slave bus,
  output logic         md_busy,
  output logic         md_done,
  output logic         dbg_state
);
  typedef struct packed {
    logic [4:0]  pc_sel;
    logic [2:0]  alu_src1;
    logic [3:0]  alu_src2;
    logic [19:0] alu_op;
    logic        mem_en;
    logic        mem_wen;
    logic        rf_wen;
    logic [2:0]  rf_wdata_sel;
    logic [2:0]  rf_waddr_sel;
    logic        hi_wen;
    logic        lo_wen;
    logic        temp_wen;
    logic        illegal;
  } ctrl_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam ctrl_t      CTRL_RESET = ctrl_t'({5'b00001, {($bits(ctrl_t) - 5){1'b0}}});
  localparam logic [5:0] MUL_LAST   = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST   = 6'(DIV_CYCLES - 1);

  ctrl_t      dec;
  ctrl_t      out_q;
  logic       out_valid_q;
  logic       legal;
  logic       wr_rd;
  logic       wr_rt;
  logic       link31;
  logic       hilo_use;
  logic       md_in_reg;
  logic       accept;
  logic       md_start;
  state_t     state;
  logic [5:0] cnt;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_inst_bits;

  assign op               = bus.inst[31:26];
  assign rt               = bus.inst[20:16];
  assign funct            = bus.inst[5:0];
  assign unused_inst_bits = ^{bus.inst[25:21], bus.inst[15:6]};

  always_comb begin
    dec          = '0;
    dec.pc_sel   = 5'b00001;
    dec.alu_src1 = 3'b001;
    dec.alu_src2 = 4'b0001;
    legal        = 1'b1;
    wr_rd        = 1'b0;
    wr_rt        = 1'b0;
    link31       = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b000000: begin dec.alu_src1 = 3'b010; dec.alu_op[8]  = 1'b1; wr_rd = 1'b1; end
          6'b000010: begin dec.alu_src1 = 3'b010; dec.alu_op[9]  = 1'b1; wr_rd = 1'b1; end
          6'b000011: begin dec.alu_src1 = 3'b010; dec.alu_op[10] = 1'b1; wr_rd = 1'b1; end
          6'b000100: begin dec.alu_op[8]  = 1'b1; wr_rd = 1'b1; end
          6'b000110: begin dec.alu_op[9]  = 1'b1; wr_rd = 1'b1; end
          6'b000111: begin dec.alu_op[10] = 1'b1; wr_rd = 1'b1; end
          // rt is $0 for JR/JALR, so rs + rt carries the target into temp
          6'b001000: begin dec.pc_sel = 5'b01000; dec.alu_op[0] = 1'b1; dec.temp_wen = 1'b1; end
          6'b001001: begin
            dec.pc_sel       = 5'b01000;
            dec.alu_op[0]    = 1'b1;
            dec.temp_wen     = 1'b1;
            dec.rf_wen       = 1'b1;
            dec.rf_wdata_sel = 3'b100;
            dec.rf_waddr_sel = 3'b001;
          end
          6'b010000: begin dec.alu_src2 = 4'b0100; dec.alu_op[0] = 1'b1; wr_rd = 1'b1; end
          6'b010001: begin dec.alu_op[0] = 1'b1; dec.hi_wen = 1'b1; end
          6'b010010: begin dec.alu_src2 = 4'b1000; dec.alu_op[0] = 1'b1; wr_rd = 1'b1; end
          6'b010011: begin dec.alu_op[0] = 1'b1; dec.lo_wen = 1'b1; end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec.alu_op[15:12] = 4'b0001 << funct[1:0];
            dec.hi_wen        = 1'b1;
            dec.lo_wen        = 1'b1;
          end
          6'b100000, 6'b100001: begin dec.alu_op[0] = 1'b1; wr_rd = 1'b1; end
          6'b100010, 6'b100011: begin dec.alu_op[1] = 1'b1; wr_rd = 1'b1; end
          6'b100100: begin dec.alu_op[4] = 1'b1; wr_rd = 1'b1; end
          6'b100101: begin dec.alu_op[6] = 1'b1; wr_rd = 1'b1; end
          6'b100110: begin dec.alu_op[7] = 1'b1; wr_rd = 1'b1; end
          6'b100111: begin dec.alu_op[5] = 1'b1; wr_rd = 1'b1; end
          6'b101010: begin dec.alu_op[2] = 1'b1; wr_rd = 1'b1; end
          6'b101011: begin dec.alu_op[3] = 1'b1; wr_rd = 1'b1; end
          default:   legal = 1'b0;
        endcase
      end
      6'b000001: begin
        dec.pc_sel = 5'b10000;
        case (rt)
          5'b00000: dec.alu_op[18] = 1'b1;
          5'b00001: dec.alu_op[19] = 1'b1;
          5'b10000: begin dec.alu_op[18] = 1'b1; link31 = 1'b1; end
          5'b10001: begin dec.alu_op[19] = 1'b1; link31 = 1'b1; end
          default:  legal = 1'b0;
        endcase
      end
      6'b000010: begin dec.pc_sel = 5'b00100; dec.alu_op[0] = 1'b1; end
      6'b000011: begin dec.pc_sel = 5'b00100; dec.alu_op[0] = 1'b1; link31 = 1'b1; end
      6'b000100: begin dec.pc_sel = 5'b10000; dec.alu_op[16] = 1'b1; end
      6'b000101: begin dec.pc_sel = 5'b10000; dec.alu_op[17] = 1'b1; end
      6'b000110: begin dec.pc_sel = 5'b10000; dec.alu_op[18] = 1'b1; end
      6'b000111: begin dec.pc_sel = 5'b10000; dec.alu_op[19] = 1'b1; end
      6'b001000, 6'b001001: begin dec.alu_src2 = 4'b0010; dec.alu_op[0]  = 1'b1; wr_rt = 1'b1; end
      6'b001010: begin dec.alu_src2 = 4'b0010; dec.alu_op[2]  = 1'b1; wr_rt = 1'b1; end
      6'b001011: begin dec.alu_src2 = 4'b0010; dec.alu_op[3]  = 1'b1; wr_rt = 1'b1; end
      6'b001100: begin dec.alu_src2 = 4'b0010; dec.alu_op[4]  = 1'b1; wr_rt = 1'b1; end
      6'b001101: begin dec.alu_src2 = 4'b0010; dec.alu_op[6]  = 1'b1; wr_rt = 1'b1; end
      6'b001110: begin dec.alu_src2 = 4'b0010; dec.alu_op[7]  = 1'b1; wr_rt = 1'b1; end
      6'b001111: begin dec.alu_src2 = 4'b0010; dec.alu_op[11] = 1'b1; wr_rt = 1'b1; end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec.alu_src2     = 4'b0010;
        dec.alu_op[0]    = 1'b1;
        dec.mem_en       = 1'b1;
        dec.rf_wen       = 1'b1;
        dec.rf_wdata_sel = 3'b010;
        dec.rf_waddr_sel = 3'b010;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.alu_src2  = 4'b0010;
        dec.alu_op[0] = 1'b1;
        dec.mem_en    = 1'b1;
        dec.mem_wen   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (wr_rd || wr_rt) begin
      dec.rf_wen       = 1'b1;
      dec.rf_wdata_sel = 3'b001;
      dec.rf_waddr_sel = wr_rd ? 3'b001 : 3'b010;
    end
    if (link31) begin
      dec.rf_wen       = 1'b1;
      dec.rf_wdata_sel = 3'b100;
      dec.rf_waddr_sel = 3'b100;
    end
    if (!legal) begin
      dec         = CTRL_RESET;
      dec.illegal = 1'b1;
    end
  end

  // Valid/ready: an instruction moves on an edge with in_valid & in_ready, a bundle on
  // out_valid & out_ready; neither side may withdraw or change its offer while waiting.
  assign hilo_use  = (op == 6'b000000) && ((funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110));
  assign md_in_reg = out_valid_q && (out_q.alu_op[15:12] != 4'b0000);
  assign bus.in_ready = ~bus.flush & (~out_valid_q | bus.out_ready)
                      & ~(hilo_use & (md_busy | md_in_reg));
  assign accept   = bus.in_valid & bus.in_ready;
  assign md_start = md_in_reg & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= CTRL_RESET;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= dec;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Flush never aborts a running unit; only a consumed md bundle starts one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: if (md_start) begin
          state <= BUSY;
          cnt   <= (out_q.alu_op[15:14] != 2'b00) ? DIV_LAST : MUL_LAST;
        end
        BUSY: if (cnt == 6'd0) begin
          state   <= IDLE;
          md_done <= 1'b1;
        end else begin
          cnt <= cnt - 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md_busy   = (state == BUSY);
  assign dbg_state = state;

  assign bus.out_valid        = out_valid_q;
  assign bus.out_pc_sel       = out_q.pc_sel;
  assign bus.out_alu_src1     = out_q.alu_src1;
  assign bus.out_alu_src2     = out_q.alu_src2;
  assign bus.out_alu_op       = out_q.alu_op;
  assign bus.out_mem_en       = out_q.mem_en;
  assign bus.out_mem_wen      = out_q.mem_wen;
  assign bus.out_rf_wen       = out_q.rf_wen;
  assign bus.out_rf_wdata_sel = out_q.rf_wdata_sel;
  assign bus.out_rf_waddr_sel = out_q.rf_waddr_sel;
  assign bus.out_hi_wen       = out_q.hi_wen;
  assign bus.out_lo_wen       = out_q.lo_wen;
  assign bus.out_temp_wen     = out_q.temp_wen;
  assign bus.out_illegal      = out_q.illegal;
endmodule

// File: tb/tb_id_ctrl_seq.sv
// Bench for id_ctrl_seq: table-driven decode vectors streamed at full rate, then
// hand-written sequences for the HI/LO interlock, flush and asynchronous reset.
module tb_id_ctrl_seq;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  typedef logic [44:0] bundle_t;
  typedef struct {
    string       name;
    logic [31:0] inst;
    bundle_t     exp;
  } vec_t;

  logic clk;
  logic rst;
  logic md_busy;
  logic md_done;
  logic dbg_state;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];

  id_ctrl_seq_if bus ();

  id_ctrl_seq #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bundle layout {pc, src1, src2, op, mem_en, mem_wen, rf_wen, wdata, waddr, hi, lo, temp, illegal}
  function automatic bundle_t mk(logic [4:0] pc, logic [2:0] s1, logic [3:0] s2, int op,
                                 logic [1:0] mem, logic rw, logic [2:0] wd, logic [2:0] wa,
                                 logic [2:0] hlt, logic ill);
    logic [19:0] o;
    o = '0;
    if (op >= 0) o[op] = 1'b1;
    return {pc, s1, s2, o, mem, rw, wd, wa, hlt, ill};
  endfunction

  function automatic bundle_t got();
    return {bus.out_pc_sel, bus.out_alu_src1, bus.out_alu_src2, bus.out_alu_op,
            bus.out_mem_en, bus.out_mem_wen, bus.out_rf_wen, bus.out_rf_wdata_sel,
            bus.out_rf_waddr_sel, bus.out_hi_wen, bus.out_lo_wen, bus.out_temp_wen,
            bus.out_illegal};
  endfunction

  function automatic logic [31:0] r_type(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sa, logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // driver tasks
  task automatic add_vec(string name, logic [31:0] inst, bundle_t exp);
    vec_t v;
    v.name = name;
    v.inst = inst;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic chk_bit(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bun(string name, bundle_t act, bundle_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge before the edge that consumes an md bundle; returns at the
  // first negedge with md_busy low, after checking the busy window and the done pulse.
  task automatic md_window(string tag, int exp_n);
    int busy_n;
    int ir_bad;
    busy_n = 0;
    ir_bad = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (!md_busy) break;
      busy_n++;
      if (bus.in_ready) ir_bad++;
    end
    chk_int({tag, "_busy_cycles"}, busy_n, exp_n);
    chk_int({tag, "_in_ready_while_busy"}, ir_bad, 0);
    chk_bit({tag, "_md_done"}, md_done, 1'b1);
    chk_bit({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    bundle_t b_reset, b_illegal, b_mult, b_mflo, b_mthi, b_div, b_addu, b_ori;
    logic [31:0] i_mult, i_mflo, i_mthi, i_div, i_addu, i_ori;
    int busy_n, done_n, bad_n;

    n_vec = 0;
    n_err = 0;
    b_reset   = mk(5'b00001, 3'b000, 4'b0000, -1, 2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    b_illegal = mk(5'b00001, 3'b000, 4'b0000, -1, 2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1);
    b_addu    = mk(5'b00001, 3'b001, 4'b0001, 0,  2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0);
    b_ori     = mk(5'b00001, 3'b001, 4'b0010, 6,  2'b00, 1'b1, 3'b001, 3'b010, 3'b000, 1'b0);
    b_mult    = mk(5'b00001, 3'b001, 4'b0001, 12, 2'b00, 1'b0, 3'b000, 3'b000, 3'b110, 1'b0);
    b_div     = mk(5'b00001, 3'b001, 4'b0001, 14, 2'b00, 1'b0, 3'b000, 3'b000, 3'b110, 1'b0);
    b_mflo    = mk(5'b00001, 3'b001, 4'b1000, 0,  2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0);
    b_mthi    = mk(5'b00001, 3'b001, 4'b0001, 0,  2'b00, 1'b0, 3'b000, 3'b000, 3'b100, 1'b0);
    i_addu = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
    i_ori  = i_type(6'b001101, 5'd1, 5'd7, 16'h00ff);
    i_mult = r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'b011000);
    i_div  = r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'b011010);
    i_mflo = r_type(5'd0, 5'd0, 5'd4, 5'd0, 6'b010010);
    i_mthi = r_type(5'd6, 5'd0, 5'd0, 5'd0, 6'b010001);

    add_vec("addu",   i_addu, b_addu);
    add_vec("lw",     i_type(6'b100011, 5'd1, 5'd5, 16'h0010),
            mk(5'b00001, 3'b001, 4'b0010, 0, 2'b10, 1'b1, 3'b010, 3'b010, 3'b000, 1'b0));
    add_vec("sw",     i_type(6'b101011, 5'd1, 5'd6, 16'h0020),
            mk(5'b00001, 3'b001, 4'b0010, 0, 2'b11, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0));
    add_vec("beq",    i_type(6'b000100, 5'd1, 5'd2, 16'h0004),
            mk(5'b10000, 3'b001, 4'b0001, 16, 2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0));
    add_vec("jal",    {6'b000011, 26'h0000100},
            mk(5'b00100, 3'b001, 4'b0001, 0, 2'b00, 1'b1, 3'b100, 3'b100, 3'b000, 1'b0));
    add_vec("sll",    r_type(5'd0, 5'd2, 5'd3, 5'd4, 6'b000000),
            mk(5'b00001, 3'b010, 4'b0001, 8, 2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0));
    add_vec("sra",    r_type(5'd0, 5'd2, 5'd3, 5'd1, 6'b000011),
            mk(5'b00001, 3'b010, 4'b0001, 10, 2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0));
    add_vec("srlv",   r_type(5'd4, 5'd2, 5'd3, 5'd0, 6'b000110),
            mk(5'b00001, 3'b001, 4'b0001, 9, 2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0));
    add_vec("ori",    i_ori, b_ori);
    add_vec("lui",    i_type(6'b001111, 5'd0, 5'd7, 16'h1234),
            mk(5'b00001, 3'b001, 4'b0010, 11, 2'b00, 1'b1, 3'b001, 3'b010, 3'b000, 1'b0));
    add_vec("sltiu",  i_type(6'b001011, 5'd3, 5'd8, 16'h0005),
            mk(5'b00001, 3'b001, 4'b0010, 3, 2'b00, 1'b1, 3'b001, 3'b010, 3'b000, 1'b0));
    add_vec("jr",     r_type(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000),
            mk(5'b01000, 3'b001, 4'b0001, 0, 2'b00, 1'b0, 3'b000, 3'b000, 3'b001, 1'b0));
    add_vec("jalr",   r_type(5'd5, 5'd0, 5'd31, 5'd0, 6'b001001),
            mk(5'b01000, 3'b001, 4'b0001, 0, 2'b00, 1'b1, 3'b100, 3'b001, 3'b001, 1'b0));
    add_vec("bgezal", i_type(6'b000001, 5'd3, 5'b10001, 16'h0008),
            mk(5'b10000, 3'b001, 4'b0001, 19, 2'b00, 1'b1, 3'b100, 3'b100, 3'b000, 1'b0));
    add_vec("bltz",   i_type(6'b000001, 5'd3, 5'b00000, 16'h0008),
            mk(5'b10000, 3'b001, 4'b0001, 18, 2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0));
    add_vec("bgtz",   i_type(6'b000111, 5'd3, 5'd0, 16'h0008),
            mk(5'b10000, 3'b001, 4'b0001, 19, 2'b00, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0));
    add_vec("mfhi",   r_type(5'd0, 5'd0, 5'd8, 5'd0, 6'b010000),
            mk(5'b00001, 3'b001, 4'b0100, 0, 2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0));
    add_vec("mtlo",   r_type(5'd9, 5'd0, 5'd0, 5'd0, 6'b010011),
            mk(5'b00001, 3'b001, 4'b0001, 0, 2'b00, 1'b0, 3'b000, 3'b000, 3'b010, 1'b0));
    add_vec("slt",    r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b101010),
            mk(5'b00001, 3'b001, 4'b0001, 2, 2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0));
    add_vec("nor",    r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100111),
            mk(5'b00001, 3'b001, 4'b0001, 5, 2'b00, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0));
    add_vec("lbu",    i_type(6'b100100, 5'd1, 5'd5, 16'h0003),
            mk(5'b00001, 3'b001, 4'b0010, 0, 2'b10, 1'b1, 3'b010, 3'b010, 3'b000, 1'b0));
    add_vec("ill_op",    {6'b111111, 26'h155aa55}, b_illegal);
    add_vec("ill_funct", r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b111111), b_illegal);
    add_vec("ill_regimm", i_type(6'b000001, 5'd1, 5'b00010, 16'h0001), b_illegal);

    // reset values
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inst      = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk_bit("rst_out_valid", bus.out_valid, 1'b0);
    chk_bun("rst_bundle", got(), b_reset);
    chk_bit("rst_md_busy", md_busy, 1'b0);
    chk_bit("rst_md_done", md_done, 1'b0);
    chk_bit("rst_state", dbg_state, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // decode table streamed one instruction per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk_bit({vecs[i-1].name, "_out_valid"}, bus.out_valid, 1'b1);
        chk_bun(vecs[i-1].name, got(), vecs[i-1].exp);
      end
      bus.in_valid  = 1'b1;
      bus.inst      = vecs[i].inst;
      bus.out_ready = 1'b1;
      #1 chk_bit({vecs[i].name, "_in_ready"}, bus.in_ready, 1'b1);
    end
    @(negedge clk);
    chk_bit({vecs[vecs.size()-1].name, "_out_valid"}, bus.out_valid, 1'b1);
    chk_bun(vecs[vecs.size()-1].name, got(), vecs[vecs.size()-1].exp);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // MULT then MFLO
    bus.in_valid = 1'b1;
    bus.inst     = i_mult;
    #1 chk_bit("mult_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk_bun("mult_bundle", got(), b_mult);
    bus.inst = i_mflo;
    #1 chk_bit("mflo_blocked_by_reg", bus.in_ready, 1'b0);
    md_window("mul", MUL_N);
    @(negedge clk);
    chk_bit("mflo_out_valid", bus.out_valid, 1'b1);
    chk_bun("mflo_bundle", got(), b_mflo);
    chk_bit("mul_done_once", md_done, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // MULT held in the output register, MTHI waits for consume plus busy window
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst      = i_mult;
    @(negedge clk);
    chk_bun("held_mult_bundle", got(), b_mult);
    bus.inst = i_mthi;
    for (int k = 0; k < 3; k++) begin
      #1 chk_bit("mthi_held_in_ready", bus.in_ready, 1'b0);
      chk_bit("mthi_held_md_busy", md_busy, 1'b0);
      @(negedge clk);
    end
    chk_bit("held_mult_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    #1 chk_bit("mthi_consume_in_ready", bus.in_ready, 1'b0);
    md_window("mthi", MUL_N);
    @(negedge clk);
    chk_bit("mthi_out_valid", bus.out_valid, 1'b1);
    chk_bun("mthi_bundle", got(), b_mthi);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // DIV with an independent stream during BUSY
    bus.in_valid = 1'b1;
    bus.inst     = i_div;
    #1 chk_bit("div_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk_bun("div_bundle", got(), b_div);
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      bus.inst = (k % 2 == 0) ? i_addu : i_ori;
      #1 chk_bit("stream_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      chk_bit("stream_out_valid", bus.out_valid, 1'b1);
      chk_bun("stream_bundle", got(), (k % 2 == 0) ? b_addu : b_ori);
      busy_n += int'(md_busy);
      done_n += int'(md_done);
    end
    chk_int("div_busy_cycles", busy_n, DIV_N);
    chk_int("div_done_pulses", done_n, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // flush with in_valid: nothing accepted
    bus.in_valid = 1'b1;
    bus.inst     = i_addu;
    bus.flush    = 1'b1;
    #1 chk_bit("flush_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk_bit("flush_out_valid", bus.out_valid, 1'b0);

    // flushed, never-consumed MULT must not start the unit
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst      = i_mult;
    @(negedge clk);
    chk_bit("fl_mult_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk_bit("fl_mult_squashed", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    bad_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bad_n += int'(md_busy);
    end
    chk_int("fl_mult_no_busy", bad_n, 0);

    // flush together with out_ready on a valid MULT still counts as consumed
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst      = i_mult;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk_bit("flc_out_valid", bus.out_valid, 1'b0);
    busy_n = 0;
    for (int j = 0; j < 100; j++) begin
      if (!md_busy) break;
      busy_n++;
      @(negedge clk);
    end
    chk_int("flc_busy_cycles", busy_n, MUL_N);
    chk_bit("flc_md_done", md_done, 1'b1);

    // asynchronous reset in the middle of a DIV busy window
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inst     = i_div;
    @(negedge clk);
    bus.inst = i_addu;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk_bit("pre_rst_busy", md_busy, 1'b1);
    chk_bit("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_bit("arst_out_valid", bus.out_valid, 1'b0);
    chk_bun("arst_bundle", got(), b_reset);
    chk_bit("arst_md_busy", md_busy, 1'b0);
    chk_bit("arst_state", dbg_state, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      done_n += int'(md_done);
      busy_n += int'(md_busy);
    end
    chk_int("arst_no_done", done_n, 0);
    chk_int("arst_no_busy", busy_n, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
